// File: rtl/key_entry.sv
`default_nettype none
// ============================================================================
// Module      : key_entry
// Description : Instruction entry front-end. Synchronises and debounces the
//               four data switches plus the ENTER and CLEAR buttons, turns
//               button presses into single-cycle pulses, and shifts one hex
//               nibble per ENTER into a 16-bit word. VALID is raised when
//               four nibbles are present and held until the control unit
//               returns ACK.
// Revision    : 1.0 - initial release
// ============================================================================
module key_entry #(
    parameter int DB_CYCLES = 250000,
    parameter int CNT_W     = 18
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] X,
    input  logic       ENT,
    input  logic       CLR,
    input  logic       ACK,
    output logic [3:0] S0,
    output logic [3:0] S1,
    output logic [3:0] S2,
    output logic [3:0] S3,
    output logic [2:0] DIGITS,
    output logic       VALID
);

    // Conditioned inputs, packed as {CLR, ENT, X[3:0]}
    localparam int c_NUM_IN  = 6;
    localparam int c_ENT_BIT = 4;
    localparam int c_CLR_BIT = 5;

    // Counter value at which a persistent difference is accepted
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ENTRY = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    logic [c_NUM_IN-1:0] w_raw;
    logic [c_NUM_IN-1:0] w_db;
    logic [3:0]          w_xdb;
    logic                w_ent_p;
    logic                w_clr_p;

    logic                r_ent_d;
    logic                r_clr_d;
    state_t              r_state;
    logic [15:0]         r_word;
    logic [2:0]          r_digits;
    logic                r_valid;

    assign w_raw = {CLR, ENT, X};

    // ------------------------------------------------------------------------
    // Per-bit conditioning: 2-flop synchroniser followed by a counter that
    // only lets the debounced value follow after DB_CYCLES consecutive clocks
    // of disagreement. Any agreement restarts the count, so short glitches
    // are absorbed.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < c_NUM_IN; gi++) begin : g_cond
        logic             r_sync1;
        logic             r_sync2;
        logic             r_db;
        logic [CNT_W-1:0] r_cnt;

        // Synchronise the raw bit and debounce the synchronised value
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_db    <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_raw[gi];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    r_db  <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end

        assign w_db[gi] = r_db;
    end

    assign w_xdb = w_db[3:0];

    // ------------------------------------------------------------------------
    // Press detection: one-cycle pulse on the rising edge of the debounced
    // buttons only; releases are ignored.
    // ------------------------------------------------------------------------

    // Remember last cycle's debounced button levels
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ent_d <= 1'b0;
            r_clr_d <= 1'b0;
        end else begin
            r_ent_d <= w_db[c_ENT_BIT];
            r_clr_d <= w_db[c_CLR_BIT];
        end
    end

    assign w_ent_p = w_db[c_ENT_BIT] & ~r_ent_d;
    assign w_clr_p = w_db[c_CLR_BIT] & ~r_clr_d;

    // ------------------------------------------------------------------------
    // Entry state machine. CLEAR wins over everything; in FULL an ACK wins
    // over a simultaneous ENTER, which is dropped. After ACK the old word
    // stays on the displays until the first nibble of the next word, which
    // replaces it entirely rather than shifting into it.
    // ------------------------------------------------------------------------

    // Word assembly, digit count and VALID handshake
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= ST_EMPTY;
            r_word   <= 16'h0000;
            r_digits <= 3'd0;
            r_valid  <= 1'b0;
        end else if (w_clr_p) begin
            r_state  <= ST_EMPTY;
            r_word   <= 16'h0000;
            r_digits <= 3'd0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_ent_p) begin
                        r_word   <= {12'h000, w_xdb};
                        r_digits <= 3'd1;
                        r_state  <= ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (w_ent_p) begin
                        r_word   <= {r_word[11:0], w_xdb};
                        r_digits <= r_digits + 3'd1;
                        if (r_digits == 3'd3) begin
                            r_state <= ST_FULL;
                            r_valid <= 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    if (ACK) begin
                        r_valid  <= 1'b0;
                        r_digits <= 3'd0;
                        r_state  <= ST_EMPTY;
                    end
                end
                default: begin
                    r_state  <= ST_EMPTY;
                    r_word   <= 16'h0000;
                    r_digits <= 3'd0;
                    r_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign S0     = r_word[3:0];
    assign S1     = r_word[7:4];
    assign S2     = r_word[11:8];
    assign S3     = r_word[15:12];
    assign DIGITS = r_digits;
    assign VALID  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_key_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_entry
// Description : Self-checking bench for key_entry with DB_CYCLES = 4.
//               A window-based behavioural model predicts the outputs every
//               cycle; directed scenarios add hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_entry;

    localparam int DB = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [3:0] X = 4'h0;
    logic       ENT = 1'b0;
    logic       CLR = 1'b0;
    logic       ACK = 1'b0;
    logic [3:0] S0, S1, S2, S3;
    logic [2:0] DIGITS;
    logic       VALID;

    int n_vec = 0;
    int n_err = 0;

    key_entry #(
        .DB_CYCLES(DB),
        .CNT_W    (3)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .X     (X),
        .ENT   (ENT),
        .CLR   (CLR),
        .ACK   (ACK),
        .S0    (S0),
        .S1    (S1),
        .S2    (S2),
        .S3    (S3),
        .DIGITS(DIGITS),
        .VALID (VALID)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Behavioural model. A conditioned bit follows its synchronised value
    // (raw delayed two clocks) once the last DB synchronised samples all
    // disagree with it. Presses are rising edges of conditioned buttons.
    // ------------------------------------------------------------------
    logic [5:0]  m_raw_d1, m_raw_d2;
    logic [5:0]  m_hist [DB];
    logic [5:0]  m_db, m_db_prev;
    logic [15:0] m_word;
    int          m_digits;
    logic        m_valid;

    function automatic void model_reset();
        m_raw_d1 = '0;
        m_raw_d2 = '0;
        for (int k = 0; k < DB; k++) m_hist[k] = '0;
        m_db      = '0;
        m_db_prev = '0;
        m_word    = 16'h0000;
        m_digits  = 0;
        m_valid   = 1'b0;
    endfunction

    function automatic void model_step(logic [5:0] raw, logic ack);
        logic       press, clear, all_diff;
        logic [5:0] sync_now;
        press = m_db[4] & ~m_db_prev[4];
        clear = m_db[5] & ~m_db_prev[5];
        if (clear) begin
            m_word = 16'h0000; m_digits = 0; m_valid = 1'b0;
        end else if (ack && m_valid) begin
            m_valid = 1'b0; m_digits = 0;
        end else if (press && !m_valid) begin
            if (m_digits == 0) m_word = {12'h000, m_db[3:0]};
            else               m_word = {m_word[11:0], m_db[3:0]};
            m_digits = m_digits + 1;
            m_valid  = (m_digits == 4);
        end
        sync_now = m_raw_d2;
        for (int k = DB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = sync_now;
        m_db_prev = m_db;
        for (int b = 0; b < 6; b++) begin
            all_diff = 1'b1;
            for (int k = 0; k < DB; k++)
                if (m_hist[k][b] == m_db[b]) all_diff = 1'b0;
            if (all_diff) m_db[b] = sync_now[b];
        end
        m_raw_d2 = m_raw_d1;
        m_raw_d1 = raw;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) model_reset();
            else        model_step({CLR, ENT, X}, ACK);
        end
    end

    // Per-cycle comparison of all outputs against the model
    initial begin
        forever begin
            @(negedge CLK);
            n_vec++;
            if ({S3, S2, S1, S0} !== m_word || DIGITS !== 3'(m_digits) || VALID !== m_valid) begin
                n_err++;
                $display("FAIL cycle@%0t word got %h exp %h, digits got %0d exp %0d, valid got %b exp %b",
                         $time, {S3, S2, S1, S0}, m_word, DIGITS, m_digits, VALID, m_valid);
            end
        end
    end

    // Literal expectation
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [15:0] word, input int dig, input logic val);
        check({name, " word"},   {S3, S2, S1, S0}, word);
        check({name, " digits"}, 16'(DIGITS), 16'(dig));
        check({name, " valid"},  16'(VALID), 16'(val));
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press(input logic [3:0] x);
        X = x;
        wait_clk(8);
        ENT = 1'b1;
        wait_clk(8);
        ENT = 1'b0;
        wait_clk(8);
    endtask

    initial begin
        wait_clk(3);
        RST_N = 1'b1;

        // Idle after reset
        wait_clk(20);
        check_out("idle", 16'h0000, 0, 1'b0);

        // Four nibbles fill the word
        press(4'hA);
        press(4'h3);
        press(4'hF);
        press(4'h1);
        check_out("full", 16'hA3F1, 4, 1'b1);

        // ENTER while full is ignored
        press(4'h5);
        check_out("full ent", 16'hA3F1, 4, 1'b1);

        // ACK releases the word but leaves it displayed
        ACK = 1'b1;
        wait_clk(1);
        ACK = 1'b0;
        check_out("ack", 16'hA3F1, 0, 1'b0);

        // First nibble of a new word replaces the old one
        press(4'h7);
        check_out("new word", 16'h0007, 1, 1'b0);

        // Two-clock glitch on ENTER is absorbed
        ENT = 1'b1;
        wait_clk(2);
        ENT = 1'b0;
        wait_clk(12);
        check_out("glitch", 16'h0007, 1, 1'b0);

        // ACK during entry is ignored
        press(4'h2);
        ACK = 1'b1;
        wait_clk(1);
        ACK = 1'b0;
        wait_clk(2);
        check_out("ack entry", 16'h0072, 2, 1'b0);

        // CLEAR and ENTER together: clear wins
        X   = 4'h9;
        CLR = 1'b1;
        ENT = 1'b1;
        wait_clk(8);
        CLR = 1'b0;
        ENT = 1'b0;
        wait_clk(8);
        check_out("clear", 16'h0000, 0, 1'b0);
        press(4'h4);
        check_out("after clear", 16'h0004, 1, 1'b0);

        // Asynchronous reset mid-entry
        press(4'h1);
        press(4'h2);
        check_out("three", 16'h0412, 3, 1'b0);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1 check_out("async rst", 16'h0000, 0, 1'b0);
        wait_clk(3);
        RST_N = 1'b1;
        press(4'h9);
        check_out("restart", 16'h0009, 1, 1'b0);

        wait_clk(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
